tilexy_ring_inject_arb: RTL and testbench

- Arbiter and sequencer for the injection port of one tile's X/Y ring cache-line FIFO.
- Shares that single port between NREQ local requesters (cache slices) using round-robin.
- Per-direction credits (fwd/back along the FIFO's ring axis) prevent ring overflow.
- Holds the presented request stable while the FIFO asserts wrt_stall.

---
 rtl/tilexy_ring_inject_arb_if.sv | 26 ++
 rtl/tilexy_ring_inject_arb.sv | 171 +++++++++++++++++
 tb/tb_tilexy_ring_inject_arb.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/tilexy_ring_inject_arb_if.sv
// Injection-port bundle between the local requesters and one ring FIFO.
// The arbiter uses the master view; the requester/FIFO side uses the slave view.
interface tilexy_ring_inject_arb_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*43-1:0]  req_addr;
  logic [NREQ*528-1:0] req_data;
  logic [NREQ*12-1:0]  req_size;
  logic                out_en;
  logic [42:0]         out_addr;
  logic [527:0]        out_datum;
  logic [11:0]         out_size;
  logic                wrt_stall;

  modport master (
    input  req_valid, req_addr, req_data, req_size, wrt_stall,
    output req_ready, out_en, out_addr, out_datum, out_size
  );

  modport slave (
    output req_valid, req_addr, req_data, req_size, wrt_stall,
    input  req_ready, out_en, out_addr, out_datum, out_size
  );
endinterface

// File: rtl/tilexy_ring_inject_arb.sv
// Round-robin arbiter/sequencer for one tile's X/Y ring FIFO injection port with
// per-direction ring credits. Define TILEXY_ARB_STATS_EN to add grant/stall counters.
module tilexy_ring_inject_arb #(
  parameter int unsigned TILE_X  = 0,
  parameter int unsigned TILE_Y  = 0,
  parameter int unsigned IDX     = 0,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CREDITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  tilexy_ring_inject_arb_if.master   bus,
  input  logic                       crd_ret_fwd,
  input  logic                       crd_ret_back,
  output logic [3:0]                 crd_fwd,
  output logic [3:0]                 crd_back,
  output logic                       crd_err
`ifdef TILEXY_ARB_STATS_EN
  ,
  output logic [31:0]                stat_grants,
  output logic [31:0]                stat_stall
`endif
);

  localparam int unsigned PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  CRD_MAX = 4'(CREDITS);
  localparam logic [4:0]  OWN     = (IDX < 2) ? 5'(TILE_X) : 5'(TILE_Y);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, sel;
  logic [NREQ-1:0] dir_fwd, elig, ready;
  logic            any_elig, grant, sel_fwd;
  logic            fwd_dec, back_dec;
  logic [4:0]      fwd_upd, back_upd;
  logic [42:0]     sel_addr;
  logic [527:0]    sel_data;
  logic [11:0]     sel_size;
  logic [42:0]     out_addr_q;
  logic [527:0]    out_datum_q;
  logic [11:0]     out_size_q;

  function automatic logic [4:0] ring_coord(input logic [42:0] a);
    return (IDX < 2) ? a[37:33] : a[42:38];
  endfunction

  // Returns {overflow, next count}; simultaneous take and return cancel out.
  function automatic logic [4:0] crd_update(input logic [3:0] cur, input logic dec,
                                            input logic ret);
    logic [4:0] r;
    r = {1'b0, cur};
    if (dec && !ret) begin
      r[3:0] = cur - 4'd1;
    end else if (ret && !dec) begin
      if (cur == CRD_MAX) r[4] = 1'b1;
      else                r[3:0] = cur + 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    dir_fwd = '0;
    elig    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      dir_fwd[i] = ring_coord(bus.req_addr[i*43 +: 43]) > OWN;
      elig[i]    = bus.req_valid[i] && (dir_fwd[i] ? (crd_fwd != '0) : (crd_back != '0));
    end
  end

  // Walk downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (elig[(32'(rr_ptr) + k - 1) % NREQ]) begin
        any_elig = 1'b1;
        sel      = PW'((32'(rr_ptr) + k - 1) % NREQ);
      end
    end
  end

  always_comb begin
    grant   = any_elig && ((state == IDLE) || !bus.wrt_stall);
    sel_fwd = dir_fwd[sel];
    ready   = '0;
    if (grant) ready[sel] = 1'b1;
    fwd_dec  = grant && sel_fwd;
    back_dec = grant && !sel_fwd;
    fwd_upd  = crd_update(crd_fwd, fwd_dec, crd_ret_fwd);
    back_upd = crd_update(crd_back, back_dec, crd_ret_back);
  end

  always_comb begin
    sel_addr = bus.req_addr[32'(sel)*43 +: 43];
    sel_data = bus.req_data[32'(sel)*528 +: 528];
    sel_size = bus.req_size[32'(sel)*12 +: 12];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant) state_nxt = ISSUE;
      end
      ISSUE, HOLD: begin
        if (bus.wrt_stall) state_nxt = HOLD;
        else if (grant)    state_nxt = ISSUE;
        else               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (grant) rr_ptr <= PW'((32'(sel) + 1) % NREQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr_q  <= '0;
      out_datum_q <= '0;
      out_size_q  <= '0;
    end else if (grant) begin
      out_addr_q  <= sel_addr;
      out_datum_q <= sel_data;
      out_size_q  <= sel_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crd_fwd  <= CRD_MAX;
      crd_back <= CRD_MAX;
      crd_err  <= 1'b0;
    end else begin
      crd_fwd  <= fwd_upd[3:0];
      crd_back <= back_upd[3:0];
      if (fwd_upd[4] || back_upd[4]) crd_err <= 1'b1;
    end
  end

`ifdef TILEXY_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant)         stat_grants <= stat_grants + 32'd1;
      if (state == HOLD) stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

  assign bus.req_ready = ready;
  assign bus.out_en    = (state != IDLE);
  assign bus.out_addr  = out_addr_q;
  assign bus.out_datum = out_datum_q;
  assign bus.out_size  = out_size_q;

endmodule

// File: tb/tb_tilexy_ring_inject_arb.sv
// Directed table-driven bench for tilexy_ring_inject_arb (TILE_X=3, IDX=0), plus
// hand sequences for async reset during HOLD and credit exhaustion (CREDITS=2 instance).
module tb_tilexy_ring_inject_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       rf1, rb1, rf2, rb2;
  logic [3:0] cf1, cb1, cf2, cb2;
  logic       err1, err2;
`ifdef TILEXY_ARB_STATS_EN
  logic [31:0] sg1, ss1, sg2, ss2;
`endif

  int n_vec = 0;
  int n_err = 0;

  tilexy_ring_inject_arb_if #(.NREQ(4)) b1 ();
  tilexy_ring_inject_arb_if #(.NREQ(4)) b2 ();

  tilexy_ring_inject_arb #(.TILE_X(3), .TILE_Y(0), .IDX(0), .NREQ(4), .CREDITS(8)) dut (
    .clk(clk), .rst(rst), .bus(b1),
    .crd_ret_fwd(rf1), .crd_ret_back(rb1),
    .crd_fwd(cf1), .crd_back(cb1), .crd_err(err1)
`ifdef TILEXY_ARB_STATS_EN
    , .stat_grants(sg1), .stat_stall(ss1)
`endif
  );

  tilexy_ring_inject_arb #(.TILE_X(3), .TILE_Y(0), .IDX(0), .NREQ(4), .CREDITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2),
    .crd_ret_fwd(rf2), .crd_ret_back(rb2),
    .crd_fwd(cf2), .crd_back(cb2), .crd_err(err2)
`ifdef TILEXY_ARB_STATS_EN
    , .stat_grants(sg2), .stat_stall(ss2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] fwd;
    logic       stall;
    logic       rf;
    logic       rb;
    logic [3:0] ready;
    logic       en;
    logic [3:0] cf;
    logic [3:0] cb;
    logic       err;
    logic [2:0] line;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input int valid, input int fwd, input int stall, input int rf,
                              input int rb, input int ready, input int en, input int cf,
                              input int cb, input int err, input int line);
    vec_t v;
    v.valid = 4'(valid); v.fwd = 4'(fwd); v.stall = 1'(stall); v.rf = 1'(rf); v.rb = 1'(rb);
    v.ready = 4'(ready); v.en = 1'(en); v.cf = 4'(cf); v.cb = 4'(cb); v.err = 1'(err);
    v.line = 3'(line);
    return v;
  endfunction

  task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester i carries line address i+1; fwd[i] picks TX=5 (fwd) or TX=1 (back).
  task automatic drive1(input logic [3:0] valid, input logic [3:0] fwd, input logic stall,
                        input logic rf, input logic rb);
    b1.req_valid = valid;
    b1.wrt_stall = stall;
    rf1 = rf;
    rb1 = rb;
    for (int i = 0; i < 4; i++) begin
      b1.req_addr[i*43 +: 43]   = {5'd0, (fwd[i] ? 5'd5 : 5'd1), 33'(i + 1)};
      b1.req_data[i*528 +: 528] = {66{8'(i + 1)}};
      b1.req_size[i*12 +: 12]   = 12'(i + 1);
    end
  endtask

  task automatic chk_line(input string tag, input logic [2:0] line);
    chk({tag, ".out_addr"}, 528'(b1.out_addr[32:0]), 528'(line));
    chk({tag, ".out_datum"}, b1.out_datum, {66{5'd0, line}});
    chk({tag, ".out_size"}, 528'(b1.out_size), 528'(line));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] c_ready [7];
    logic       c_en    [7];
    logic [3:0] c_cf    [7];
    logic       c_rf    [7];

    //         valid    fwd     st rf rb ready    en cf cb er ln
    tbl[0]  = mk('b1111, 'b0000, 0, 0, 0, 'b0001, 0, 8, 8, 0, 0);
    tbl[1]  = mk('b1111, 'b0000, 0, 0, 0, 'b0010, 1, 8, 7, 0, 1);
    tbl[2]  = mk('b1111, 'b0000, 0, 0, 0, 'b0100, 1, 8, 6, 0, 2);
    tbl[3]  = mk('b1111, 'b0000, 0, 0, 0, 'b1000, 1, 8, 5, 0, 3);
    tbl[4]  = mk('b1111, 'b0000, 0, 0, 0, 'b0001, 1, 8, 4, 0, 4);
    tbl[5]  = mk('b0000, 'b0000, 0, 0, 0, 'b0000, 1, 8, 3, 0, 1);
    tbl[6]  = mk('b0000, 'b0000, 0, 0, 1, 'b0000, 0, 8, 3, 0, 1);
    tbl[7]  = mk('b0010, 'b0000, 0, 0, 1, 'b0010, 0, 8, 4, 0, 1);
    tbl[8]  = mk('b0000, 'b0000, 0, 0, 1, 'b0000, 1, 8, 4, 0, 2);
    tbl[9]  = mk('b0000, 'b0000, 0, 0, 1, 'b0000, 0, 8, 5, 0, 2);
    tbl[10] = mk('b0000, 'b0000, 0, 0, 1, 'b0000, 0, 8, 6, 0, 2);
    tbl[11] = mk('b0000, 'b0000, 0, 0, 1, 'b0000, 0, 8, 7, 0, 2);
    tbl[12] = mk('b0000, 'b0000, 0, 1, 0, 'b0000, 0, 8, 8, 0, 2);
    tbl[13] = mk('b0000, 'b0000, 0, 0, 0, 'b0000, 0, 8, 8, 1, 2);
    tbl[14] = mk('b0001, 'b0001, 0, 0, 0, 'b0001, 0, 8, 8, 1, 2);
    tbl[15] = mk('b0000, 'b0000, 0, 0, 0, 'b0000, 1, 7, 8, 1, 1);
    tbl[16] = mk('b0000, 'b0000, 0, 0, 0, 'b0000, 0, 7, 8, 1, 1);
    tbl[17] = mk('b0100, 'b0000, 0, 0, 0, 'b0100, 0, 7, 8, 1, 1);
    tbl[18] = mk('b1000, 'b0000, 1, 0, 0, 'b0000, 1, 7, 7, 1, 3);
    tbl[19] = mk('b1000, 'b0000, 1, 0, 0, 'b0000, 1, 7, 7, 1, 3);
    tbl[20] = mk('b1000, 'b0000, 1, 0, 0, 'b0000, 1, 7, 7, 1, 3);
    tbl[21] = mk('b1000, 'b0000, 0, 0, 0, 'b1000, 1, 7, 7, 1, 3);
    tbl[22] = mk('b0000, 'b0000, 0, 0, 0, 'b0000, 1, 7, 6, 1, 4);
    tbl[23] = mk('b0000, 'b0000, 0, 0, 0, 'b0000, 0, 7, 6, 1, 4);

    rst = 1'b1;
    drive1('0, '0, 1'b0, 1'b0, 1'b0);
    b2.req_valid = '0;
    b2.wrt_stall = 1'b0;
    b2.req_addr  = '0;
    b2.req_data  = '0;
    b2.req_size  = '0;
    rf2 = 1'b0;
    rb2 = 1'b0;
    #2;
    chk("reset.out_en", 528'(b1.out_en), 528'(0));
    chk("reset.req_ready", 528'(b1.req_ready), 528'(0));
    chk("reset.crd_fwd", 528'(cf1), 528'(8));
    chk("reset.crd_back", 528'(cb1), 528'(8));
    chk("reset.crd_err", 528'(err1), 528'(0));
    chk_line("reset", 3'd0);
    chk("reset2.crd_fwd", 528'(cf2), 528'(2));
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 24; v++) begin
      @(negedge clk);
      drive1(tbl[v].valid, tbl[v].fwd, tbl[v].stall, tbl[v].rf, tbl[v].rb);
      #1;
      chk($sformatf("v%0d.req_ready", v), 528'(b1.req_ready), 528'(tbl[v].ready));
      chk($sformatf("v%0d.out_en", v), 528'(b1.out_en), 528'(tbl[v].en));
      chk($sformatf("v%0d.crd_fwd", v), 528'(cf1), 528'(tbl[v].cf));
      chk($sformatf("v%0d.crd_back", v), 528'(cb1), 528'(tbl[v].cb));
      chk($sformatf("v%0d.crd_err", v), 528'(err1), 528'(tbl[v].err));
      chk_line($sformatf("v%0d", v), tbl[v].line);
    end

`ifdef TILEXY_ARB_STATS_EN
    chk("stats.grants", 528'(sg1), 528'(9));
    chk("stats.stall", 528'(ss1), 528'(3));
`endif

    // Async reset while HOLD: grant req1 (back), stall it, then pulse rst mid-cycle.
    @(negedge clk);
    drive1(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
    #1 chk("rsthold.grant", 528'(b1.req_ready), 528'(4'b0010));
    @(negedge clk);
    drive1(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    #1 chk("rsthold.issue_en", 528'(b1.out_en), 528'(1));
    @(negedge clk);
    #1 chk("rsthold.hold_en", 528'(b1.out_en), 528'(1));
    chk("rsthold.crd_back_pre", 528'(cb1), 528'(5));
    #1 rst = 1'b1;
    #1;
    chk("rsthold.out_en", 528'(b1.out_en), 528'(0));
    chk("rsthold.crd_fwd", 528'(cf1), 528'(8));
    chk("rsthold.crd_back", 528'(cb1), 528'(8));
    chk("rsthold.crd_err", 528'(err1), 528'(0));
    chk("rsthold.out_addr", 528'(b1.out_addr), 528'(0));
    #1 rst = 1'b0;
    @(negedge clk);
    drive1(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    #1 chk("rsthold.rr_ptr0", 528'(b1.req_ready), 528'(4'b0001));
    @(negedge clk);
    drive1(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Credit exhaustion on the CREDITS=2 instance: req0 fwd held valid, one return pulse.
    c_ready = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    c_en    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    c_cf    = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
    c_rf    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    b2.req_addr[42:0] = {5'd0, 5'd5, 33'd1};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      b2.req_valid = 4'b0001;
      rf2 = c_rf[c];
      #1;
      chk($sformatf("exh%0d.req_ready", c), 528'(b2.req_ready), 528'(c_ready[c]));
      chk($sformatf("exh%0d.out_en", c), 528'(b2.out_en), 528'(c_en[c]));
      chk($sformatf("exh%0d.crd_fwd", c), 528'(cf2), 528'(c_cf[c]));
    end
    chk("exh.crd_err", 528'(err2), 528'(0));
    @(negedge clk);
    b2.req_valid = '0;
    rf2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
